// File: rtl/user_mgr_arb.sv
// user_mgr_arb: round-robin OBI arbiter from NumReq requesters onto one manager port.
// Ports: req/addr/we/be/wdata per requester in, gnt/rvalid per requester out,
//   rdata/err broadcast out, mgr_* downstream OBI A/R channels, proto_err sticky flag.
module user_mgr_arb #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned BeW      = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][BeW-1:0]          be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                err_o,
    output logic                                mgr_req_o,
    output logic [AddrWidth-1:0]                mgr_addr_o,
    output logic                                mgr_we_o,
    output logic [BeW-1:0]                      mgr_be_o,
    output logic [DataWidth-1:0]                mgr_wdata_o,
    input  logic                                mgr_gnt_i,
    input  logic                                mgr_rvalid_i,
    input  logic [DataWidth-1:0]                mgr_rdata_i,
    input  logic                                mgr_err_i,
    output logic                                proto_err_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_valid_q;
    logic [IdxW-1:0] rr_winner;
    logic [IdxW-1:0] winner;
    logic            locked;
    logic            full;
    logic            empty;
    logic            handshake;
    logic            pop;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [IdxW-1:0] id_q [MaxTrans];
    logic [IdxW-1:0] head;
    logic            proto_err_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin : rr_scan
        logic            found;
        logic [IdxW-1:0] cand;
        found     = 1'b0;
        cand      = '0;
        rr_winner = rr_ptr_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
            if (!found && req_i[cand]) begin
                rr_winner = cand;
                found     = 1'b1;
            end
        end
    end

    // A stalled winner keeps the port only while it still requests.
    assign locked    = lock_valid_q && req_i[lock_idx_q];
    assign winner    = locked ? lock_idx_q : rr_winner;
    assign full      = (count_q == CntW'(MaxTrans));
    assign empty     = (count_q == '0);
    assign mgr_req_o = (|req_i) && !full;
    assign handshake = mgr_req_o && mgr_gnt_i;
    assign pop       = mgr_rvalid_i && !empty;
    assign head      = id_q[rd_ptr_q];

    assign mgr_addr_o  = addr_i[winner];
    assign mgr_we_o    = we_i[winner];
    assign mgr_be_o    = be_i[winner];
    assign mgr_wdata_o = wdata_i[winner];

    assign rdata_o     = mgr_rdata_i;
    assign err_o       = mgr_err_i;
    assign proto_err_o = proto_err_q;

    always_comb begin
        gnt_o          = '0;
        rvalid_o       = '0;
        gnt_o[winner]  = handshake;
        rvalid_o[head] = pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
        end else begin
            lock_valid_q <= mgr_req_o && !mgr_gnt_i;
            if (mgr_req_o && !mgr_gnt_i) begin
                lock_idx_q <= winner;
            end
            if (handshake) begin
                rr_ptr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({handshake, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (mgr_rvalid_i && empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_q[wr_ptr_q] <= winner;
        end
    end

endmodule

// File: doc/user_mgr_arb.md
USER_MGR_ARB -- requirements
Module: user_mgr_arb

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of OBI requesters (2..8).
REQ-002 SHALL have parameter MaxTrans, default 2, maximum outstanding transactions (1..8).
REQ-003 SHALL have parameter AddrWidth, default 32, address width.
REQ-004 SHALL have parameter DataWidth, default 32, data width; byte-enable width BeW = DataWidth/8.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_i  in  NumReq  per-requester request.
REQ-008 addr_i  in  NumReq x AddrWidth  per-requester address.
REQ-009 we_i  in  NumReq  per-requester write enable.
REQ-010 be_i  in  NumReq x BeW  per-requester byte enables.
REQ-011 wdata_i  in  NumReq x DataWidth  per-requester write data.
REQ-012 gnt_o  out  NumReq  per-requester grant, one-hot or zero.
REQ-013 rvalid_o  out  NumReq  per-requester response valid, one-hot or zero.
REQ-014 rdata_o  out  DataWidth  response data, broadcast to all requesters.
REQ-015 err_o  out  1  response error, broadcast.
REQ-016 mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o  out  1/AddrWidth/1/BeW/DataWidth  downstream OBI A-channel.
REQ-017 mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i  in  1/1/DataWidth/1  downstream OBI grant and R-channel.
REQ-018 proto_err_o  out  1  sticky flag: response received with nothing outstanding.

Function
REQ-019 Arbitration SHALL be round-robin: winner is the first asserted req_i at or after index rr_ptr, wrapping modulo NumReq.
REQ-020 mgr_req_o SHALL be high when any req_i is high and outstanding count < MaxTrans; the A-channel mirrors the winner's signals combinationally.
REQ-021 Grant SHALL pass through combinationally: gnt_o[winner] = mgr_gnt_i and mgr_req_o; all other gnt_o are 0.
REQ-022 On handshake (mgr_req_o and mgr_gnt_i), rr_ptr SHALL update to (winner+1) mod NumReq at the next edge; otherwise rr_ptr holds.
REQ-023 Lock: when mgr_req_o is high and mgr_gnt_i is low, the winner index SHALL be registered and held as winner until handshake, even if a higher-priority requester arrives.
REQ-024 If the locked requester drops req_i, the lock SHALL clear in the same cycle; arbitration resumes normally.
REQ-025 An ID FIFO of depth MaxTrans SHALL push the winner index on handshake and pop on mgr_rvalid_i.
REQ-026 rvalid_o[FIFO head] SHALL equal mgr_rvalid_i; rdata_o = mgr_rdata_i; err_o = mgr_err_i; no added latency.
REQ-027 Outstanding count SHALL increment on handshake, decrement on mgr_rvalid_i, and hold when both occur in the same cycle.
REQ-028 When count == MaxTrans, mgr_req_o and all gnt_o SHALL be 0 even if mgr_rvalid_i is high that cycle; issue resumes the next cycle.
REQ-029 mgr_rvalid_i with an empty FIFO SHALL be ignored (no rvalid_o, no count change) and SHALL set proto_err_o until reset.
REQ-030 Responses SHALL be returned in issue order; the block performs no reordering.

Reset
REQ-031 While rst_ni is low: rr_ptr = 0, lock cleared, FIFO empty, count = 0, proto_err_o = 0; outputs derive from these (gnt_o, rvalid_o, mgr_req_o are 0 when inputs are idle).
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset release set proto_err_o.

Verification
REQ-033 Both req_i high, mgr_gnt_i always 1, 4 cycles -> grants alternate 0,1,0,1; rvalid_o is routed in the same order.
REQ-034 req_i[1] high, mgr_gnt_i held 0 for 3 cycles, req_i[0] rises in cycle 2 -> mgr_addr_o stays addr_i[1]; gnt_o[1] asserts on the first gnt.
REQ-035 MaxTrans=2, two handshakes, no rvalid -> mgr_req_o=0 on the third request; rvalid in cycle N -> mgr_req_o=1 in cycle N+1.
REQ-036 Handshake and mgr_rvalid_i in the same cycle with count=1 -> count stays 1; the correct requester's rvalid_o fires.
REQ-037 mgr_rvalid_i with nothing outstanding -> rvalid_o=0, proto_err_o=1; stays 1 until rst_ni is low.
REQ-038 rst_ni pulled low with 2 outstanding, then released -> count=0, rr_ptr=0; the next request from requester 0 is granted first.
